trap_ctrl: RTL and testbench
============================

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-002 SHALL have commit_valid  in  1  an instruction is at the commit point this cycle.
REQ-003 SHALL have commit_pc  in  64  PC of the committing instruction.
REQ-004 SHALL have commit_exc  in  1  the committing instruction raised a synchronous exception.
REQ-005 SHALL have commit_code  in  63  exception cause code.
REQ-006 SHALL have commit_mret  in  1  the committing instruction is MRET.
REQ-007 SHALL have mem_busy  in  1  a data-memory transaction is outstanding.
REQ-008 SHALL have csr_mie_g  in  1 (global mstatus.MIE) and csr_mie_en  in  3 (mie bits {11,7,3}).
REQ-009 SHALL have csr_mtvec and csr_mepc  in  64  current CSR values.
REQ-010 SHALL have irq_timer, irq_sw, irq_ext  in  1 each  asynchronous interrupt levels.
REQ-011 SHALL have csr_enter and csr_leave  out  1  one-cycle CSR update strobes.
REQ-012 SHALL have csr_pc  out  64 and csr_code  out  63  trap PC and cause.
REQ-013 SHALL have csr_itype  out  3  0 NONE, 1 EXCEPTION, 2 TIMER, 3 SOFTWARE, 4 EXTERNAL.
REQ-014 SHALL have flush, stall_commit, redirect_valid  out  1 and redirect_pc  out  64.

Function
REQ-015 SHALL pass each irq input through a 2-flop synchronizer; only synchronized levels are used; csr_itype reflects the synchronized levels in IDLE, the latched kind otherwise.
REQ-016 SHALL implement FSM states IDLE, DRAIN, ENTER, LEAVE, REDIRECT.
REQ-017 Pending interrupt = csr_mie_g AND (sync irq AND enable); priority external(code 11) > software(3) > timer(7).
REQ-018 In IDLE with commit_valid: pending interrupt takes priority over commit_exc, which takes priority over commit_mret.
REQ-019 On a take decision SHALL latch pc=commit_pc, code, and kind (interrupt/exception/mret), then enter DRAIN next cycle; the committing instruction is suppressed (not retired).
REQ-020 No take decision SHALL occur when commit_valid=0; interrupts wait for the next commit.
REQ-021 flush SHALL be 1 in every DRAIN cycle; stall_commit SHALL be 1 in every non-IDLE state.
REQ-022 DRAIN SHALL last at least 2 cycles and exit only in a cycle where mem_busy=0 and the minimum has elapsed; exit to LEAVE for mret, else ENTER.
REQ-023 ENTER SHALL assert csr_enter for exactly one cycle with csr_pc/csr_code/csr_itype from the latch; interrupt codes per REQ-017.
REQ-024 LEAVE SHALL assert csr_leave for exactly one cycle; csr_pc/csr_code are 0 and csr_itype is NONE.
REQ-025 REDIRECT SHALL follow ENTER/LEAVE: redirect_valid=1 for one cycle, redirect_pc=csr_mtvec (after enter) or csr_mepc (after leave), sampled that cycle; then IDLE.
REQ-026 Commits and irq changes during non-IDLE states SHALL be ignored; the latched trap is unaffected.
REQ-027 Trap latency from decision to redirect SHALL be 4 cycles when mem_busy=0.
REQ-028 csr_enter and csr_leave SHALL never be high in the same cycle.

Reset
REQ-029 reset SHALL force IDLE, clear latches, synchronizers and the drain counter, and drive all outputs to 0 on the next edge, including mid-trap.

Verification
REQ-030 Exception: commit_valid=1, commit_exc=1, code=2, pc=0x8000_0010, mtvec=0x8000_1000 -> flush 2 cycles, csr_enter with itype=1, code=2, csr_pc=0x8000_0010, then redirect_pc=0x8000_1000.
REQ-031 MRET: commit_mret=1, csr_mepc=0x8000_0014 -> csr_leave pulse, then redirect_pc=0x8000_0014, no csr_enter.
REQ-032 Simultaneous irq_ext+irq_timer synced, enables=3'b111, mie_g=1, commit_exc=1 -> code=11, itype=4, mepc=commit_pc.
REQ-033 mie_g=0 with irq_timer high for 20 commits -> no trap; set mie_g=1 -> trap with code 7.
REQ-034 mem_busy held 5 cycles in DRAIN -> flush held 5 cycles, csr_enter in the cycle after mem_busy falls.
REQ-035 reset asserted in ENTER -> no csr_enter or redirect; all outputs 0; IDLE afterwards.

Source files
------------

// File: rtl/trap_ctrl.sv
// Trap sequencing at the commit point: decides on interrupts, exceptions and MRET,
// drains the pipeline, pulses the CSR update strobe and redirects fetch.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | watching commits; csr_itype shows synchronized irq levels
// DRAIN    | flushing the pipeline, waiting out the minimum and mem_busy
// ENTER    | one-cycle csr_enter with latched pc/code/kind
// LEAVE    | one-cycle csr_leave for MRET
// REDIRECT | one-cycle fetch redirect to mtvec (trap) or mepc (mret)
module trap_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        commit_valid,
    input  logic [63:0] commit_pc,
    input  logic        commit_exc,
    input  logic [62:0] commit_code,
    input  logic        commit_mret,
    input  logic        mem_busy,
    input  logic        csr_mie_g,
    input  logic [2:0]  csr_mie_en,
    input  logic [63:0] csr_mtvec,
    input  logic [63:0] csr_mepc,
    input  logic        irq_timer,
    input  logic        irq_sw,
    input  logic        irq_ext,
    output logic        csr_enter,
    output logic        csr_leave,
    output logic [63:0] csr_pc,
    output logic [62:0] csr_code,
    output logic [2:0]  csr_itype,
    output logic        flush,
    output logic        stall_commit,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc
);

    localparam logic [2:0] ITYPE_NONE  = 3'd0;
    localparam logic [2:0] ITYPE_EXC   = 3'd1;
    localparam logic [2:0] ITYPE_TIMER = 3'd2;
    localparam logic [2:0] ITYPE_SW    = 3'd3;
    localparam logic [2:0] ITYPE_EXT   = 3'd4;

    localparam logic [62:0] CODE_SW    = 63'd3;
    localparam logic [62:0] CODE_TIMER = 63'd7;
    localparam logic [62:0] CODE_EXT   = 63'd11;

    // Two DRAIN cycles minimum: the counter is loaded with one and must reach zero first.
    localparam logic [1:0] DRAIN_LOAD = 2'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_ENTER,
        S_LEAVE,
        S_REDIRECT
    } state_t;

    state_t      state;
    logic [1:0]  drain_cnt;
    logic [63:0] lat_pc;
    logic [62:0] lat_code;
    logic [2:0]  lat_itype;
    logic        lat_mret;

    // Bit order {ext, timer, sw} lines up with the mie enable bits {11, 7, 3}.
    logic [2:0]  irq_meta;
    logic [2:0]  irq_sync;
    logic [2:0]  irq_pend;

    logic        irq_take;
    logic [62:0] irq_code;
    logic [2:0]  irq_itype;
    logic [2:0]  idle_itype;
    logic        take;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_meta <= '0;
            irq_sync <= '0;
        end else begin
            irq_meta <= {irq_ext, irq_timer, irq_sw};
            irq_sync <= irq_meta;
        end
    end

    assign irq_pend = irq_sync & csr_mie_en & {3{csr_mie_g}};

    always_comb begin
        irq_take  = 1'b0;
        irq_code  = '0;
        irq_itype = ITYPE_NONE;
        if (irq_pend[2]) begin
            irq_take  = 1'b1;
            irq_code  = CODE_EXT;
            irq_itype = ITYPE_EXT;
        end else if (irq_pend[0]) begin
            irq_take  = 1'b1;
            irq_code  = CODE_SW;
            irq_itype = ITYPE_SW;
        end else if (irq_pend[1]) begin
            irq_take  = 1'b1;
            irq_code  = CODE_TIMER;
            irq_itype = ITYPE_TIMER;
        end
    end

    // Unmasked view of the synchronized levels, shown on csr_itype while idle.
    always_comb begin
        idle_itype = ITYPE_NONE;
        if (irq_sync[2]) begin
            idle_itype = ITYPE_EXT;
        end else if (irq_sync[0]) begin
            idle_itype = ITYPE_SW;
        end else if (irq_sync[1]) begin
            idle_itype = ITYPE_TIMER;
        end
    end

    assign take = commit_valid && (irq_take || commit_exc || commit_mret);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            drain_cnt      <= '0;
            lat_pc         <= '0;
            lat_code       <= '0;
            lat_itype      <= ITYPE_NONE;
            lat_mret       <= 1'b0;
            csr_enter      <= 1'b0;
            csr_leave      <= 1'b0;
            csr_pc         <= '0;
            csr_code       <= '0;
            flush          <= 1'b0;
            stall_commit   <= 1'b0;
            redirect_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (take) begin
                        state        <= S_DRAIN;
                        drain_cnt    <= DRAIN_LOAD;
                        lat_pc       <= commit_pc;
                        flush        <= 1'b1;
                        stall_commit <= 1'b1;
                        if (irq_take) begin
                            lat_code  <= irq_code;
                            lat_itype <= irq_itype;
                            lat_mret  <= 1'b0;
                        end else if (commit_exc) begin
                            lat_code  <= commit_code;
                            lat_itype <= ITYPE_EXC;
                            lat_mret  <= 1'b0;
                        end else begin
                            lat_code  <= '0;
                            lat_itype <= ITYPE_NONE;
                            lat_mret  <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt != 2'd0) begin
                        drain_cnt <= drain_cnt - 2'd1;
                    end else if (!mem_busy) begin
                        flush <= 1'b0;
                        if (lat_mret) begin
                            state     <= S_LEAVE;
                            csr_leave <= 1'b1;
                        end else begin
                            state     <= S_ENTER;
                            csr_enter <= 1'b1;
                            csr_pc    <= lat_pc;
                            csr_code  <= lat_code;
                        end
                    end
                end
                S_ENTER: begin
                    state          <= S_REDIRECT;
                    csr_enter      <= 1'b0;
                    csr_pc         <= '0;
                    csr_code       <= '0;
                    redirect_valid <= 1'b1;
                end
                S_LEAVE: begin
                    state          <= S_REDIRECT;
                    csr_leave      <= 1'b0;
                    redirect_valid <= 1'b1;
                end
                S_REDIRECT: begin
                    state          <= S_IDLE;
                    redirect_valid <= 1'b0;
                    stall_commit   <= 1'b0;
                end
                default: begin
                    state          <= S_IDLE;
                    csr_enter      <= 1'b0;
                    csr_leave      <= 1'b0;
                    flush          <= 1'b0;
                    stall_commit   <= 1'b0;
                    redirect_valid <= 1'b0;
                end
            endcase
        end
    end

    // MRET carries ITYPE_NONE in its latch, so LEAVE and its REDIRECT report NONE.
    assign csr_itype   = (state == S_IDLE) ? idle_itype : lat_itype;
    assign redirect_pc = redirect_valid ? (lat_mret ? csr_mepc : csr_mtvec) : 64'd0;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: exceptions, MRET, interrupt priority and masking,
// drain stretching by mem_busy, back-to-back traps and reset mid-trap.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        commit_valid;
    logic [63:0] commit_pc;
    logic        commit_exc;
    logic [62:0] commit_code;
    logic        commit_mret;
    logic        mem_busy;
    logic        csr_mie_g;
    logic [2:0]  csr_mie_en;
    logic [63:0] csr_mtvec;
    logic [63:0] csr_mepc;
    logic        irq_timer;
    logic        irq_sw;
    logic        irq_ext;
    logic        csr_enter;
    logic        csr_leave;
    logic [63:0] csr_pc;
    logic [62:0] csr_code;
    logic [2:0]  csr_itype;
    logic        flush;
    logic        stall_commit;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    // {csr_enter, csr_leave, flush, stall_commit, redirect_valid}
    logic [4:0]  ctl;
    assign ctl = {csr_enter, csr_leave, flush, stall_commit, redirect_valid};

    localparam logic [4:0] C_IDLE     = 5'b00000;
    localparam logic [4:0] C_DRAIN    = 5'b00110;
    localparam logic [4:0] C_ENTER    = 5'b10010;
    localparam logic [4:0] C_LEAVE    = 5'b01010;
    localparam logic [4:0] C_REDIRECT = 5'b00011;

    int errors = 0;
    int checks = 0;

    trap_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .commit_valid   (commit_valid),
        .commit_pc      (commit_pc),
        .commit_exc     (commit_exc),
        .commit_code    (commit_code),
        .commit_mret    (commit_mret),
        .mem_busy       (mem_busy),
        .csr_mie_g      (csr_mie_g),
        .csr_mie_en     (csr_mie_en),
        .csr_mtvec      (csr_mtvec),
        .csr_mepc       (csr_mepc),
        .irq_timer      (irq_timer),
        .irq_sw         (irq_sw),
        .irq_ext        (irq_ext),
        .csr_enter      (csr_enter),
        .csr_leave      (csr_leave),
        .csr_pc         (csr_pc),
        .csr_code       (csr_code),
        .csr_itype      (csr_itype),
        .flush          (flush),
        .stall_commit   (stall_commit),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        commit_valid = 0; commit_pc = '0; commit_exc = 0; commit_code = '0;
        commit_mret = 0; mem_busy = 0; csr_mie_g = 0; csr_mie_en = 3'b000;
        csr_mtvec = 64'h8000_1000; csr_mepc = 64'h8000_0014;
        irq_timer = 0; irq_sw = 0; irq_ext = 0;
        repeat (3) step();
        checks++;
        if (ctl !== C_IDLE) begin
            errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, C_IDLE);
        end
        checks++;
        if ({csr_pc, csr_code, csr_itype, redirect_pc} !== '0) begin
            errors++; $display("FAIL reset_data: pc=%0h code=%0h itype=%0d rpc=%0h expected all 0",
                               csr_pc, csr_code, csr_itype, redirect_pc);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_exception();
        commit_valid = 1; commit_exc = 1; commit_code = 63'd2; commit_pc = 64'h8000_0010;
        csr_mtvec = 64'h8000_1000;
        checks++;
        if (ctl !== C_IDLE) begin
            errors++; $display("FAIL exc_decision_cycle: got %b expected %b", ctl, C_IDLE);
        end
        step();
        // Commit arriving during DRAIN must not disturb the latched trap.
        commit_code = 63'd9; commit_pc = 64'h0000_dead;
        checks++;
        if (ctl !== C_DRAIN || csr_itype !== 3'd1) begin
            errors++; $display("FAIL exc_drain1: ctl=%b itype=%0d expected %b/1", ctl, csr_itype, C_DRAIN);
        end
        step();
        commit_valid = 0; commit_exc = 0;
        checks++;
        if (ctl !== C_DRAIN) begin
            errors++; $display("FAIL exc_drain2: got %b expected %b", ctl, C_DRAIN);
        end
        step();
        checks++;
        if (ctl !== C_ENTER || csr_pc !== 64'h8000_0010 || csr_code !== 63'd2 || csr_itype !== 3'd1) begin
            errors++; $display("FAIL exc_enter: ctl=%b pc=%0h code=%0d itype=%0d expected %b/80000010/2/1",
                               ctl, csr_pc, csr_code, csr_itype, C_ENTER);
        end
        step();
        checks++;
        if (ctl !== C_REDIRECT || redirect_pc !== 64'h8000_1000) begin
            errors++; $display("FAIL exc_redirect: ctl=%b rpc=%0h expected %b/80001000", ctl, redirect_pc, C_REDIRECT);
        end
        step();
        checks++;
        if (ctl !== C_IDLE || redirect_pc !== 64'd0) begin
            errors++; $display("FAIL exc_idle: ctl=%b rpc=%0h expected %b/0", ctl, redirect_pc, C_IDLE);
        end
    endtask

    task automatic test_mret();
        commit_valid = 1; commit_mret = 1; commit_pc = 64'h8000_0020;
        csr_mepc = 64'h8000_0014;
        step();
        commit_valid = 0; commit_mret = 0;
        checks++;
        if (ctl !== C_DRAIN) begin
            errors++; $display("FAIL mret_drain: got %b expected %b", ctl, C_DRAIN);
        end
        step();
        step();
        checks++;
        if (ctl !== C_LEAVE || csr_pc !== 64'd0 || csr_code !== 63'd0 || csr_itype !== 3'd0) begin
            errors++; $display("FAIL mret_leave: ctl=%b pc=%0h code=%0d itype=%0d expected %b/0/0/0",
                               ctl, csr_pc, csr_code, csr_itype, C_LEAVE);
        end
        step();
        checks++;
        if (ctl !== C_REDIRECT || redirect_pc !== 64'h8000_0014) begin
            errors++; $display("FAIL mret_redirect: ctl=%b rpc=%0h expected %b/80000014", ctl, redirect_pc, C_REDIRECT);
        end
        step();
        checks++;
        if (ctl !== C_IDLE) begin
            errors++; $display("FAIL mret_idle: got %b expected %b", ctl, C_IDLE);
        end
    endtask

    task automatic test_irq_priority();
        csr_mie_g = 1; csr_mie_en = 3'b111; irq_ext = 1; irq_timer = 1;
        step(); step();
        checks++;
        if (stall_commit !== 1'b0 || csr_itype !== 3'd4) begin
            errors++; $display("FAIL irq_no_commit: stall=%b itype=%0d expected 0/4", stall_commit, csr_itype);
        end
        commit_valid = 1; commit_exc = 1; commit_code = 63'd5; commit_pc = 64'h0000_1234;
        step();
        commit_valid = 0; commit_exc = 0; irq_ext = 0;
        step();
        checks++;
        if (ctl !== C_DRAIN || csr_itype !== 3'd4) begin
            errors++; $display("FAIL irq_latched_kind: ctl=%b itype=%0d expected %b/4", ctl, csr_itype, C_DRAIN);
        end
        step();
        checks++;
        if (ctl !== C_ENTER || csr_code !== 63'd11 || csr_itype !== 3'd4 || csr_pc !== 64'h0000_1234) begin
            errors++; $display("FAIL irq_ext_enter: ctl=%b code=%0d itype=%0d pc=%0h expected %b/11/4/1234",
                               ctl, csr_code, csr_itype, csr_pc, C_ENTER);
        end
        step(); step();
        // Timer still pending; software must win over it.
        irq_sw = 1;
        step(); step();
        commit_valid = 1; commit_pc = 64'h0000_2000;
        step();
        commit_valid = 0;
        step(); step();
        checks++;
        if (ctl !== C_ENTER || csr_code !== 63'd3 || csr_itype !== 3'd3 || csr_pc !== 64'h0000_2000) begin
            errors++; $display("FAIL irq_sw_enter: ctl=%b code=%0d itype=%0d pc=%0h expected %b/3/3/2000",
                               ctl, csr_code, csr_itype, csr_pc, C_ENTER);
        end
        step(); step();
        irq_sw = 0; irq_timer = 0; csr_mie_g = 0;
        repeat (3) step();
    endtask

    task automatic test_irq_masked();
        int traps = 0;
        csr_mie_g = 0; csr_mie_en = 3'b111; irq_timer = 1;
        step(); step();
        checks++;
        if (csr_itype !== 3'd2) begin
            errors++; $display("FAIL idle_itype_timer: got %0d expected 2", csr_itype);
        end
        for (int i = 0; i < 20; i++) begin
            commit_valid = 1; commit_pc = 64'h100 + 64'(i * 4);
            step();
            if (stall_commit !== 1'b0) traps++;
        end
        commit_valid = 0;
        checks++;
        if (traps !== 0) begin
            errors++; $display("FAIL masked_no_trap: got %0d trap cycles expected 0", traps);
        end
        csr_mie_g = 1;
        repeat (3) step();
        checks++;
        if (stall_commit !== 1'b0) begin
            errors++; $display("FAIL irq_waits_commit: stall=%b expected 0", stall_commit);
        end
        commit_valid = 1; commit_pc = 64'h0000_3000;
        step();
        commit_valid = 0;
        step(); step();
        checks++;
        if (ctl !== C_ENTER || csr_code !== 63'd7 || csr_itype !== 3'd2) begin
            errors++; $display("FAIL timer_enter: ctl=%b code=%0d itype=%0d expected %b/7/2",
                               ctl, csr_code, csr_itype, C_ENTER);
        end
        step(); step();
        irq_timer = 0; csr_mie_g = 0;
        repeat (3) step();
    endtask

    task automatic test_mem_busy();
        int fcount = 0;
        int gaps = 0;
        bit seen = 0;
        commit_valid = 1; commit_exc = 1; commit_code = 63'd4; commit_pc = 64'h0000_4000;
        mem_busy = 1;
        step();
        commit_valid = 0; commit_exc = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            if (csr_enter) begin
                seen = 1;
            end else begin
                if (flush) fcount++;
                else gaps++;
                mem_busy = (i < 5);
                step();
            end
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL busy_enter_timeout: csr_enter not seen within 20 cycles");
        end
        checks++;
        if (fcount !== 5 || gaps !== 0) begin
            errors++; $display("FAIL busy_flush_len: flush=%0d gaps=%0d expected 5/0", fcount, gaps);
        end
        step();
        checks++;
        if (ctl !== C_REDIRECT) begin
            errors++; $display("FAIL busy_redirect: got %b expected %b", ctl, C_REDIRECT);
        end
        mem_busy = 0;
        step();
    endtask

    task automatic test_back_to_back();
        commit_valid = 1; commit_exc = 1; commit_code = 63'd8; commit_pc = 64'h0000_0100;
        repeat (4) step();
        checks++;
        if (ctl !== C_REDIRECT) begin
            errors++; $display("FAIL b2b_latency: got %b expected %b", ctl, C_REDIRECT);
        end
        step();
        commit_code = 63'd6; commit_pc = 64'h0000_0200;
        checks++;
        if (ctl !== C_IDLE) begin
            errors++; $display("FAIL b2b_idle_gap: got %b expected %b", ctl, C_IDLE);
        end
        step();
        commit_valid = 0; commit_exc = 0;
        step(); step();
        checks++;
        if (ctl !== C_ENTER || csr_code !== 63'd6 || csr_pc !== 64'h0000_0200) begin
            errors++; $display("FAIL b2b_second: ctl=%b code=%0d pc=%0h expected %b/6/200",
                               ctl, csr_code, csr_pc, C_ENTER);
        end
        step(); step();
    endtask

    task automatic test_reset_mid_trap();
        commit_valid = 1; commit_exc = 1; commit_code = 63'd2; commit_pc = 64'h8000_0010;
        step();
        commit_valid = 0; commit_exc = 0;
        step(); step();
        checks++;
        if (csr_enter !== 1'b1) begin
            errors++; $display("FAIL rst_reach_enter: csr_enter=%b expected 1", csr_enter);
        end
        reset = 1;
        step();
        checks++;
        if (ctl !== C_IDLE || csr_pc !== 64'd0 || csr_code !== 63'd0 || csr_itype !== 3'd0 || redirect_pc !== 64'd0) begin
            errors++; $display("FAIL rst_mid_trap: ctl=%b pc=%0h code=%0d itype=%0d rpc=%0h expected all 0",
                               ctl, csr_pc, csr_code, csr_itype, redirect_pc);
        end
        reset = 0;
        step();
        checks++;
        if (ctl !== C_IDLE) begin
            errors++; $display("FAIL rst_stays_idle: got %b expected %b", ctl, C_IDLE);
        end
        commit_valid = 1; commit_exc = 1; commit_code = 63'd13;
        step();
        commit_valid = 0; commit_exc = 0;
        step(); step();
        checks++;
        if (ctl !== C_ENTER || csr_code !== 63'd13) begin
            errors++; $display("FAIL rst_then_trap: ctl=%b code=%0d expected %b/13", ctl, csr_code, C_ENTER);
        end
        step(); step();
    endtask

    initial begin
        test_reset();
        test_exception();
        test_mret();
        test_irq_priority();
        test_irq_masked();
        test_mem_busy();
        test_back_to_back();
        test_reset_mid_trap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
